// File: rtl/ysyx_22041071_div_issue.sv
// rtl/ysyx_22041071_div_issue.sv - divide issue/response sequencer; YSYX_22041071_DIV_BYPASS_EN enables local special-case resolution
module ysyx_22041071_div_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_type,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res,
  output logic        busy,
  output logic        div_valid,
  output logic        div_signed,
  output logic        divw,
  output logic [63:0] dividend,
  output logic [63:0] divisor,
  input  logic        div_ready,
  input  logic        div_out_valid,
  input  logic [63:0] quot,
  input  logic [63:0] rema,
  output logic        div_flush
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op_type;
  logic        r_res_valid;
  logic [63:0] r_res;
  logic        r_busy;
  logic        r_div_valid;
  logic        r_div_signed;
  logic        r_divw;
  logic [63:0] r_dividend;
  logic [63:0] r_divisor;

  logic        w_accept;
  logic [63:0] w_div_sel;
  logic [63:0] w_div_res;
  logic        w_bypass;
  logic [63:0] w_byp_res;

  // Acceptance needs an idle sequencer, an idle divider and no flush this cycle
  assign op_ready  = (r_state == S_IDLE) && div_ready && !flush;
  assign w_accept  = op_valid && op_ready;
  assign div_flush = flush;

  // Divider result selection; W ops always sign-extend bit 31, unsigned ones included
  assign w_div_sel = r_op_type[1] ? rema : quot;
  assign w_div_res = r_op_type[2] ? {{32{w_div_sel[31]}}, w_div_sel[31:0]} : w_div_sel;

`ifdef YSYX_22041071_DIV_BYPASS_EN
  logic        w_div_zero;
  logic        w_overflow;
  logic [63:0] w_byp_sel;

  // Special cases are judged on the incoming operands so the answer is ready at accept+1
  assign w_div_zero = op_type[2] ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
  assign w_overflow = !op_type[0] &&
                      (op_type[2] ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                                  : ((src1 == 64'h8000_0000_0000_0000) && (src2 == 64'hFFFF_FFFF_FFFF_FFFF)));
  // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend (the MIN value), r = 0
  assign w_byp_sel  = w_div_zero ? (op_type[1] ? src1 : 64'hFFFF_FFFF_FFFF_FFFF)
                                 : (op_type[1] ? 64'd0 : src1);
  assign w_byp_res  = op_type[2] ? {{32{w_byp_sel[31]}}, w_byp_sel[31:0]} : w_byp_sel;
  assign w_bypass   = w_div_zero || w_overflow;
`else
  assign w_byp_res  = 64'd0;
  assign w_bypass   = 1'b0;
`endif

  // Sequencer: issue to divider, collect result, hold it for the consumer, drain on flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op_type    <= 3'd0;
      r_res_valid  <= 1'b0;
      r_res        <= 64'd0;
      r_busy       <= 1'b0;
      r_div_valid  <= 1'b0;
      r_div_signed <= 1'b0;
      r_divw       <= 1'b0;
      r_dividend   <= 64'd0;
      r_divisor    <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_type    <= op_type;
            r_dividend   <= src1;
            r_divisor    <= src2;
            r_div_signed <= !op_type[0];
            r_divw       <= op_type[2];
            r_busy       <= 1'b1;
            if (w_bypass) begin
              r_state     <= S_RESP;
              r_res_valid <= 1'b1;
              r_res       <= w_byp_res;
            end else begin
              r_state     <= S_WAIT;
              r_div_valid <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state     <= S_DRAIN;
            r_div_valid <= 1'b0;
          end else if (div_out_valid) begin
            r_state     <= S_RESP;
            r_div_valid <= 1'b0;
            r_res_valid <= 1'b1;
            r_res       <= w_div_res;
          end
        end
        S_RESP: begin
          // Flush and consumer handshake both retire the result; res returns to zero
          if (flush || res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_res       <= 64'd0;
            r_busy      <= 1'b0;
          end
        end
        S_DRAIN: begin
          // A late result strobe from the cancelled divide is swallowed here
          if (div_ready && !div_out_valid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_div_valid <= 1'b0;
          r_res_valid <= 1'b0;
          r_res       <= 64'd0;
        end
      endcase
    end
  end

  assign res_valid  = r_res_valid;
  assign res        = r_res;
  assign busy       = r_busy;
  assign div_valid  = r_div_valid;
  assign div_signed = r_div_signed;
  assign divw       = r_divw;
  assign dividend   = r_dividend;
  assign divisor    = r_divisor;

endmodule

// File: tb/tb_ysyx_22041071_div_issue.sv
// tb/tb_ysyx_22041071_div_issue.sv - randomized bench for ysyx_22041071_div_issue with behavioural model and divider stub
module tb_ysyx_22041071_div_issue;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_RESP  = 2;
  localparam int P_DRAIN = 3;
`ifdef YSYX_22041071_DIV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, op_valid, flush, res_ready, div_ready, div_out_valid;
  logic [2:0]  op_type;
  logic [63:0] src1, src2, quot, rema;
  logic        op_ready, res_valid, busy, div_valid, div_signed, divw, div_flush;
  logic [63:0] res, dividend, divisor;

  always #5 clk = ~clk;

  ysyx_22041071_div_issue dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .src1(src1), .src2(src2), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .busy(busy), .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
    .dividend(dividend), .divisor(divisor), .div_ready(div_ready), .div_out_valid(div_out_valid),
    .quot(quot), .rema(rema), .div_flush(div_flush)
  );

  int n_chk = 0;
  int n_pass = 0;

  // next-cycle stimulus, applied at the falling edge
  logic        nx_reset, nx_op_valid, nx_flush, nx_rr;
  logic [2:0]  nx_type;
  logic [63:0] nx_a, nx_b;
  int          nx_lat;

  // behavioural model of the sequencer
  int          m_ph;
  bit          m_clean;
  logic [2:0]  m_type;
  logic [63:0] m_a, m_b, m_res;
  bit          last_acc;
  bit          obs_valid;
  logic [63:0] obs_res;

  // divider stub
  bit          sb_busy;
  int          sb_cnt, sb_drain;
  logic [63:0] sb_q, sb_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RISC-V style divide/remainder with the architectural special cases
  function automatic void ref_divrem(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] q, output logic [63:0] r);
    longint sa, sb;
    if (w) begin
      sa = s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      sb = s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
      if (sb == 0) begin q = '1; r = sa; end
      else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin q = sa; r = 64'd0; end
      else begin q = sa / sb; r = sa % sb; end
    end else if (b == 64'd0) begin
      q = '1; r = a;
    end else if (s) begin
      sa = a; sb = b;
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin q = a; r = 64'd0; end
      else begin q = sa / sb; r = sa % sb; end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  function automatic logic [63:0] golden(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r, sel;
    ref_divrem(!t[0], t[2], a, b, q, r);
    sel = t[1] ? r : q;
    return t[2] ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction

  function automatic bit special(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b);
    if (t[2]) return (b[31:0] == 32'd0) || (!t[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (!t[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'h0000_0000_FFFF_FFFF;
      5: return 64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, then compare and advance model and stub
  task automatic tick();
    bit acc;
    logic [63:0] q, r;
    @(negedge clk);
    reset = nx_reset; op_valid = nx_op_valid; op_type = nx_type;
    src1 = nx_a; src2 = nx_b; flush = nx_flush; res_ready = nx_rr;
    div_ready = !sb_busy && (sb_drain == 0);
    div_out_valid = 1'b0; quot = {$urandom, $urandom}; rema = {$urandom, $urandom};
    if (sb_busy && sb_cnt == 0) begin
      div_out_valid = 1'b1; quot = sb_q; rema = sb_r;
    end else if (!sb_busy && !div_valid && $urandom_range(0, 3) == 0) begin
      div_out_valid = 1'b1;
    end
    #1;
    chk("busy", busy, m_ph != P_IDLE);
    chk("res_valid", res_valid, m_ph == P_RESP);
    chk("res", res, (m_ph == P_RESP) ? m_res : 64'd0);
    chk("div_valid", div_valid, m_ph == P_WAIT);
    chk("op_ready", op_ready, (m_ph == P_IDLE) && div_ready && !flush);
    chk("div_flush", div_flush, flush);
    if (m_ph == P_WAIT) begin
      chk("div_signed", div_signed, !m_type[0]);
      chk("divw", divw, m_type[2]);
      chk("dividend", dividend, m_a);
      chk("divisor", divisor, m_b);
    end
    if (m_clean) begin
      chk("rst_operands", {div_signed, divw, dividend[30:0], divisor[30:0]}, 64'd0);
      chk("rst_dividend", dividend, 64'd0);
      chk("rst_divisor", divisor, 64'd0);
    end
    if (!reset && res_valid && res_ready && !flush) begin obs_valid = 1'b1; obs_res = res; end

    acc = op_valid && (m_ph == P_IDLE) && div_ready && !flush && !reset;
    last_acc = acc;
    if (reset) begin
      m_ph = P_IDLE; m_clean = 1'b1;
    end else begin
      case (m_ph)
        P_IDLE: if (acc) begin
          m_type = op_type; m_a = src1; m_b = src2; m_clean = 1'b0;
          if (BYP && special(op_type, src1, src2)) begin m_ph = P_RESP; m_res = golden(op_type, src1, src2); end
          else m_ph = P_WAIT;
        end
        P_WAIT: if (flush) m_ph = P_DRAIN;
                else if (div_out_valid) begin m_ph = P_RESP; m_res = golden(m_type, m_a, m_b); end
        P_RESP: if (flush || res_ready) m_ph = P_IDLE;
        default: if (div_ready && !div_out_valid) m_ph = P_IDLE;
      endcase
    end

    if (reset) begin
      sb_busy = 1'b0; sb_drain = 0;
    end else if (sb_busy) begin
      if (flush) begin sb_busy = 1'b0; sb_drain = $urandom_range(1, 4); end
      else if (div_out_valid) sb_busy = 1'b0;
      else if (sb_cnt > 0) sb_cnt--;
    end else if (sb_drain > 0) begin
      sb_drain--;
    end else if (div_valid && div_ready) begin
      if (flush) sb_drain = $urandom_range(0, 3);
      else begin
        ref_divrem(div_signed, divw, dividend, divisor, q, r);
        sb_q = divw ? {$urandom, q[31:0]} : q;
        sb_r = divw ? {$urandom, r[31:0]} : r;
        sb_busy = 1'b1; sb_cnt = nx_lat;
      end
    end
  endtask

  // Issue one op and run until the sequencer is idle again
  task automatic do_op(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b,
                       input int lat, input int flush_at, input int rr_hold, input int rst_at);
    bit acc;
    int resp_cnt;
    nx_type = t; nx_a = a; nx_b = b; nx_lat = lat; nx_rr = 1'b0;
    obs_valid = 1'b0; acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      nx_op_valid = ($urandom_range(0, 3) != 0);
      nx_flush = (k == 0) && ($urandom_range(0, 3) == 0);
      tick();
      acc = last_acc;
    end
    chk("accept_timeout", acc, 1);
    nx_op_valid = 1'b0;
    resp_cnt = 0;
    for (int k = 0; k < 300 && m_ph != P_IDLE; k++) begin
      nx_flush = (k == flush_at);
      nx_reset = (k == rst_at);
      if (m_ph == P_RESP) begin nx_rr = (resp_cnt >= rr_hold); resp_cnt++; end
      else nx_rr = $urandom_range(0, 1);
      tick();
    end
    chk("done_timeout", m_ph == P_IDLE, 1);
    nx_flush = 1'b0; nx_reset = 1'b0; nx_rr = 1'b0;
  endtask

  initial begin
    int fa, ra;
    reset = 1'b1; op_valid = 1'b0; op_type = 3'd0; src1 = 64'd0; src2 = 64'd0;
    flush = 1'b0; res_ready = 1'b0; div_ready = 1'b1; div_out_valid = 1'b0;
    quot = 64'd0; rema = 64'd0;
    nx_reset = 1'b1; nx_op_valid = 1'b0; nx_flush = 1'b0; nx_rr = 1'b0;
    nx_type = 3'd0; nx_a = 64'd0; nx_b = 64'd0; nx_lat = 0;
    m_ph = P_IDLE; m_clean = 1'b1; m_type = 3'd0; m_a = 64'd0; m_b = 64'd0; m_res = 64'd0;
    sb_busy = 1'b0; sb_cnt = 0; sb_drain = 0; sb_q = 64'd0; sb_r = 64'd0;
    obs_valid = 1'b0; obs_res = 64'd0; last_acc = 1'b0;

    // pin the reference model with hand-computed values
    chk("pin_div", golden(3'b000, 64'd100, -64'sd7), 64'hFFFF_FFFF_FFFF_FFF2);
    chk("pin_remu0", golden(3'b011, 64'h1234, 64'd0), 64'h1234);
    chk("pin_divovf", golden(3'b000, 64'h8000_0000_0000_0000, '1), 64'h8000_0000_0000_0000);
    chk("pin_removf", golden(3'b010, 64'h8000_0000_0000_0000, '1), 64'd0);
    chk("pin_divw", golden(3'b100, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_remuw", golden(3'b111, 64'hFFFF_FFFF, 64'h10), 64'hF);
    chk("pin_divu", golden(3'b001, 64'd81, 64'd9), 64'd9);

    for (int i = 0; i < 3; i++) tick();
    nx_reset = 1'b0;
    tick();

    do_op(3'b000, 64'd100, -64'sd7, 10, -1, 0, -1);
    chk("req020_valid", obs_valid, 1); chk("req020_res", obs_res, 64'hFFFF_FFFF_FFFF_FFF2);
    do_op(3'b011, 64'h1234, 64'd0, 5, -1, 0, -1);
    chk("req021_res", obs_res, 64'h1234);
    do_op(3'b000, 64'h8000_0000_0000_0000, '1, 4, -1, 1, -1);
    chk("req022_div", obs_res, 64'h8000_0000_0000_0000);
    do_op(3'b010, 64'h8000_0000_0000_0000, '1, 4, -1, 0, -1);
    chk("req022_rem_valid", obs_valid, 1); chk("req022_rem", obs_res, 64'd0);
    do_op(3'b100, 64'h0000_0000_FFFF_FFF9, 64'd2, 3, -1, 0, -1);
    chk("req023_divw", obs_res, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'b111, 64'hFFFF_FFFF, 64'h10, 3, -1, 0, -1);
    chk("req023_remuw", obs_res, 64'hF);
    do_op(3'b000, 64'd5000, 64'd7, 40, 20, 0, -1);
    chk("req024_flushed", obs_valid, 0);
    do_op(3'b001, 64'd81, 64'd9, 6, -1, 0, -1);
    chk("req024_divu", obs_res, 64'd9);
    do_op(3'b000, 64'd1000, 64'd10, 2, -1, 5, -1);
    chk("req025_res", obs_res, 64'd100);
    do_op(3'b000, 64'd1000, 64'd10, 30, -1, 0, 5);
    chk("reset_midop", obs_valid, 0);

    for (int i = 0; i < 160; i++) begin
      nx_lat = $urandom_range(0, 12);
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nx_lat + 3)) : -1;
      ra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, nx_lat)) : -1;
      do_op(3'($urandom_range(0, 7)), pick(), pick(), nx_lat, fa, $urandom_range(0, 3), ra);
    end
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
